// File: rtl/tl_data_mem_ctrl.sv
// TL-UL slave data memory: DEPTH-word array behind a ready/valid A channel and
// a single registered D-channel response slot, with byte-lane writes and error flagging.
module tl_data_mem_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 12,
  parameter int DEPTH        = 1024,
  parameter int SOURCE_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_valid_i,
  output logic                    a_ready_o,
  input  logic [2:0]              a_opcode_i,
  input  logic [1:0]              a_size_i,
  input  logic [SOURCE_WIDTH-1:0] a_source_i,
  input  logic [ADDR_WIDTH-1:0]   a_address_i,
  input  logic [DATA_WIDTH/8-1:0] a_mask_i,
  input  logic [DATA_WIDTH-1:0]   a_data_i,
  output logic                    d_valid_o,
  input  logic                    d_ready_i,
  output logic [2:0]              d_opcode_o,
  output logic [1:0]              d_size_o,
  output logic [SOURCE_WIDTH-1:0] d_source_o,
  output logic [DATA_WIDTH-1:0]   d_data_o,
  output logic                    d_error_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH * BYTES);
  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [2:0]              r_dOpcode;
  logic [1:0]              r_dSize;
  logic [SOURCE_WIDTH-1:0] r_dSource;
  logic [DATA_WIDTH-1:0]   r_dData;
  logic                    r_dError;

  logic                    w_dValid;
  logic                    w_aReady;
  logic                    w_accept;
  logic                    w_isGet;
  logic                    w_isPut;
  logic                    w_sizeBad;
  logic                    w_alignBad;
  logic                    w_rangeBad;
  logic                    w_error;
  logic [ADDR_WIDTH-1:0]   w_alignMask;
  logic [IDX_W-1:0]        w_idx;

  assign w_aReady = rst_n & (~w_dValid | d_ready_i);
  assign w_accept = a_valid_i & w_aReady;

  assign w_isGet     = (a_opcode_i == OP_GET);
  assign w_isPut     = (a_opcode_i == OP_PUT_FULL) || (a_opcode_i == OP_PUT_PART);
  assign w_sizeBad   = ({30'd0, a_size_i} > OFF_W);
  assign w_alignMask = ADDR_WIDTH'((32'd1 << a_size_i) - 32'd1);
  assign w_alignBad  = |(a_address_i & w_alignMask);
  assign w_rangeBad  = ({1'b0, a_address_i} >= LIMIT);
  assign w_error     = ~(w_isGet | w_isPut) | w_sizeBad | w_alignBad | w_rangeBad
                     | (w_isPut & ~|a_mask_i);
  assign w_idx       = a_address_i[OFF_W +: IDX_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A new accept always fills the slot; a bare handshake drains it.
  always_comb begin
    w_nextState = r_state;
    if (w_accept) begin
      w_nextState = FULL;
    end else if ((r_state == FULL) && d_ready_i) begin
      w_nextState = EMPTY;
    end
  end

  always_comb begin
    w_dValid = 1'b0;
    if (r_state == FULL) begin
      w_dValid = 1'b1;
    end
  end

  // Array has no reset; writes only happen for legal Puts, lane by lane.
  always_ff @(posedge clk) begin
    if (w_accept && w_isPut && !w_error) begin
      for (int b = 0; b < BYTES; b++) begin
        if (a_mask_i[b]) begin
          r_mem[w_idx][b*8 +: 8] <= a_data_i[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dOpcode <= 3'd0;
      r_dSize   <= 2'd0;
      r_dSource <= '0;
      r_dData   <= '0;
      r_dError  <= 1'b0;
    end else if (w_accept) begin
      r_dOpcode <= w_isGet ? 3'd1 : 3'd0;
      r_dSize   <= a_size_i;
      r_dSource <= a_source_i;
      r_dError  <= w_error;
      r_dData   <= (w_isGet && !w_error) ? r_mem[w_idx] : '0;
    end
  end

  assign a_ready_o  = w_aReady;
  assign d_valid_o  = w_dValid;
  assign d_opcode_o = r_dOpcode;
  assign d_size_o   = r_dSize;
  assign d_source_o = r_dSource;
  assign d_data_o   = r_dData;
  assign d_error_o  = r_dError;

endmodule
